// File: rtl/rf_pkg.sv
// Shared types for the banked register file: copy-engine states and per-bank flag bundle.
package rf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } cpy_state_t;

  typedef struct packed {
    logic zero;
    logic ngtv;
    logic scry;
  } flags_t;

endpackage

// File: rtl/rf_copy_fsm.sv
// Background bank-copy sequencer. It walks idx through every register of the
// source bank, one per cycle, and tells the storage block where to copy from/to.
// It holds no data itself; the storage write mux lives in the top.
module rf_copy_fsm
  import rf_pkg::*;
#(
  parameter int PW    = 3,
  parameter int NBANK = 2,
  parameter int BW    = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpy_req,
  input  logic [BW-1:0] cpy_bank,
  input  logic [BW-1:0] bank_cur,
  input  logic          bank_sw,
  output logic          busy,
  output logic          cpy_done,
  output logic [PW-1:0] cpy_idx,
  output logic [BW-1:0] src_bank,
  output logic [BW-1:0] dst_bank
);

  localparam int          NREG     = 2 ** PW;
  localparam logic [PW:0] LAST_IDX = (PW + 1)'(NREG - 1);

  cpy_state_t    state, state_nxt;
  logic [PW:0]   idx, idx_nxt;
  logic [BW-1:0] src, src_nxt;
  logic [BW-1:0] dst, dst_nxt;
  logic          req_ok;

  // A request is only accepted when it names a different, existing bank and no switch competes with it.
  always_comb begin
    req_ok = cpy_req && (cpy_bank != bank_cur) &&
             ({1'b0, cpy_bank} < (BW + 1)'(NBANK)) && !bank_sw;
  end

  // State, index and bank latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      src   <= '0;
      dst   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      src   <= src_nxt;
      dst   <= dst_nxt;
    end
  end

  // Next-state and outputs; the final index cycle raises cpy_done and returns to IDLE without wrapping idx.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    src_nxt   = src;
    dst_nxt   = dst;
    busy      = 1'b0;
    cpy_done  = 1'b0;
    case (state)
      IDLE: begin
        if (req_ok) begin
          state_nxt = COPY;
          idx_nxt   = '0;
          src_nxt   = bank_cur;
          dst_nxt   = cpy_bank;
        end
      end
      COPY: begin
        busy = 1'b1;
        if (idx == LAST_IDX) begin
          cpy_done  = 1'b1;
          state_nxt = IDLE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpy_idx  = idx[PW-1:0];
  assign src_bank = src;
  assign dst_bank = dst;

endmodule

// File: rtl/banked_reg_file.sv
// Banked register file between decode and ALU: NBANK banks of 2**PW DW-bit
// registers with per-bank flags, zero-latency reads, optional write bypass and
// a background engine that copies the active bank into another bank.
module banked_reg_file
  import rf_pkg::*;
#(
  parameter  int DW     = 8,
  parameter  int PW     = 3,
  parameter  int NBANK  = 2,
  parameter  int BYPASS = 0,
  localparam int BW     = $clog2(NBANK)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] dat_in,
  input  logic          wr_en,
  input  logic          flg_en,
  input  logic          zeroIn,
  input  logic          ngtvIn,
  input  logic          scryIn,
  input  logic [PW-1:0] wr_addr,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  input  logic          bank_sw,
  input  logic [BW-1:0] bank_sel,
  input  logic          cpy_req,
  input  logic [BW-1:0] cpy_bank,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          zeroOut,
  output logic          ngtvOut,
  output logic          scryOut,
  output logic [BW-1:0] bank_cur,
  output logic          busy,
  output logic          cpy_done
);

  localparam int NREG = 2 ** PW;

  logic [DW-1:0] core [NBANK][NREG];
  flags_t        flg  [NBANK];

  flags_t        flg_in;
  logic [PW-1:0] cpy_idx;
  logic [BW-1:0] src_bank;
  logic [BW-1:0] dst_bank;
  logic [DW-1:0] cpy_data;
  flags_t        cpy_flags;
  logic          sel_ok;

  assign flg_in = {zeroIn, ngtvIn, scryIn};

  rf_copy_fsm #(
    .PW    (PW),
    .NBANK (NBANK),
    .BW    (BW)
  ) u_copy_fsm (
    .clk      (clk),
    .reset    (reset),
    .cpy_req  (cpy_req),
    .cpy_bank (cpy_bank),
    .bank_cur (bank_cur),
    .bank_sw  (bank_sw),
    .busy     (busy),
    .cpy_done (cpy_done),
    .cpy_idx  (cpy_idx),
    .src_bank (src_bank),
    .dst_bank (dst_bank)
  );

  // Copy source values; a same-cycle write to the register being copied is forwarded so dst never sees stale data.
  always_comb begin
    cpy_data  = core[src_bank][cpy_idx];
    cpy_flags = flg[src_bank];
    sel_ok    = ({1'b0, bank_sel} < (BW + 1)'(NBANK));
    if (wr_en && (wr_addr == cpy_idx)) begin
      cpy_data = dat_in;
    end
    if (flg_en) begin
      cpy_flags = flg_in;
    end
  end

  // Storage, flags and active-bank register; writes always target the bank active before any switch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NBANK; b++) begin
        for (int r = 0; r < NREG; r++) begin
          core[b][r] <= '0;
        end
        flg[b] <= '0;
      end
      bank_cur <= '0;
    end else begin
      if (wr_en) begin
        core[bank_cur][wr_addr] <= dat_in;
      end
      if (flg_en) begin
        flg[bank_cur] <= flg_in;
      end
      if (busy) begin
        core[dst_bank][cpy_idx] <= cpy_data;
      end
      if (cpy_done) begin
        flg[dst_bank] <= cpy_flags;
      end
      if (bank_sw && !busy && sel_ok) begin
        bank_cur <= bank_sel;
      end
    end
  end

  // Zero-latency read ports with optional same-cycle write bypass.
  always_comb begin
    datA_out = core[bank_cur][rd_addrA];
    datB_out = core[bank_cur][rd_addrB];
    if ((BYPASS != 0) && wr_en && (wr_addr == rd_addrA)) begin
      datA_out = dat_in;
    end
    if ((BYPASS != 0) && wr_en && (wr_addr == rd_addrB)) begin
      datB_out = dat_in;
    end
  end

  assign zeroOut = flg[bank_cur].zero;
  assign ngtvOut = flg[bank_cur].ngtv;
  assign scryOut = flg[bank_cur].scry;

endmodule

// File: tb/tb_banked_reg_file.sv
// Self-checking bench for banked_reg_file: one instance without bypass, one with,
// driven by the same stimulus. Expected values go into a scoreboard when stimulus
// is applied and are popped against DUT observations at the end of each scenario.
module tb_banked_reg_file;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dat_in;
  logic       wr_en, flg_en, zeroIn, ngtvIn, scryIn;
  logic [2:0] wr_addr, rd_addrA, rd_addrB;
  logic       bank_sw, cpy_req;
  logic [0:0] bank_sel, cpy_bank;

  logic [7:0] datA_out, datB_out, datA_bp, datB_bp;
  logic       zeroOut, ngtvOut, scryOut, zero_bp, ngtv_bp, scry_bp;
  logic [0:0] bank_cur, bank_cur_bp;
  logic       busy, cpy_done, busy_bp, done_bp;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  string      sb_name[$];
  logic [15:0] sb_val[$];
  logic [15:0] obs[$];

  banked_reg_file #(.DW(8), .PW(3), .NBANK(2), .BYPASS(0)) dut (
    .clk(clk), .reset(reset), .dat_in(dat_in), .wr_en(wr_en), .flg_en(flg_en),
    .zeroIn(zeroIn), .ngtvIn(ngtvIn), .scryIn(scryIn), .wr_addr(wr_addr),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .bank_sw(bank_sw), .bank_sel(bank_sel),
    .cpy_req(cpy_req), .cpy_bank(cpy_bank), .datA_out(datA_out), .datB_out(datB_out),
    .zeroOut(zeroOut), .ngtvOut(ngtvOut), .scryOut(scryOut), .bank_cur(bank_cur),
    .busy(busy), .cpy_done(cpy_done)
  );

  banked_reg_file #(.DW(8), .PW(3), .NBANK(2), .BYPASS(1)) dut_bp (
    .clk(clk), .reset(reset), .dat_in(dat_in), .wr_en(wr_en), .flg_en(flg_en),
    .zeroIn(zeroIn), .ngtvIn(ngtvIn), .scryIn(scryIn), .wr_addr(wr_addr),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .bank_sw(bank_sw), .bank_sel(bank_sel),
    .cpy_req(cpy_req), .cpy_bank(cpy_bank), .datA_out(datA_bp), .datB_out(datB_bp),
    .zeroOut(zero_bp), .ngtvOut(ngtv_bp), .scryOut(scry_bp), .bank_cur(bank_cur_bp),
    .busy(busy_bp), .cpy_done(done_bp)
  );

  always #5 clk = ~clk;

  // Count cpy_done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (cpy_done) done_cnt++;
  end

  task automatic idle_inputs();
    reset = 1'b0; dat_in = 8'h00; wr_en = 1'b0; flg_en = 1'b0;
    zeroIn = 1'b0; ngtvIn = 1'b0; scryIn = 1'b0; wr_addr = 3'd0;
    rd_addrA = 3'd0; rd_addrB = 3'd0; bank_sw = 1'b0; bank_sel = 1'b0;
    cpy_req = 1'b0; cpy_bank = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string nm, input logic [15:0] v);
    sb_name.push_back(nm);
    sb_val.push_back(v);
  endtask

  task automatic test_reset();
    string nm; logic [15:0] ev, ov;
    idle_inputs(); reset = 1'b1; tick(); tick();
    idle_inputs();
    wr_en = 1'b1; wr_addr = 3'd3; dat_in = 8'hA5; tick();
    idle_inputs(); rd_addrA = 3'd3; expect_val("r3_written", 16'h00A5); #1;
    obs.push_back(16'(datA_out));
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; dat_in = 8'h5A; flg_en = 1'b1;
    zeroIn = 1'b1; ngtvIn = 1'b1; scryIn = 1'b1; bank_sw = 1'b1; bank_sel = 1'b1;
    cpy_req = 1'b1; cpy_bank = 1'b1;
    expect_val("r3_after_reset", 16'h0000);
    expect_val("flags_after_reset", 16'h0000);
    expect_val("bank_after_reset", 16'h0000);
    expect_val("busy_after_reset", 16'h0000);
    tick();
    idle_inputs(); rd_addrA = 3'd3; #1;
    obs.push_back(16'(datA_out));
    obs.push_back(16'({zeroOut, ngtvOut, scryOut}));
    obs.push_back(16'(bank_cur));
    obs.push_back(16'(busy));
    while (sb_val.size() != 0) begin
      nm = sb_name.pop_front(); ev = sb_val.pop_front();
      if (obs.size() != 0) ov = obs.pop_front(); else ov = 'x;
      checks++;
      if (ov !== ev) begin errors++; $display("[TB] FAIL %s: got %h expected %h", nm, ov, ev); end
    end
    obs.delete();
  endtask

  task automatic test_flag_decouple();
    string nm; logic [15:0] ev, ov;
    wr_en = 1'b1; wr_addr = 3'd2; dat_in = 8'h42; tick();
    idle_inputs();
    flg_en = 1'b1; zeroIn = 1'b1; scryIn = 1'b1; wr_addr = 3'd2; dat_in = 8'hFF;
    expect_val("flags_before_edge", 16'h0000); #1;
    obs.push_back(16'({zeroOut, ngtvOut, scryOut}));
    expect_val("flags_loaded", 16'h0005);
    expect_val("r2_untouched_by_flg", 16'h0042);
    tick(); idle_inputs(); rd_addrA = 3'd2; #1;
    obs.push_back(16'({zeroOut, ngtvOut, scryOut}));
    obs.push_back(16'(datA_out));
    wr_en = 1'b1; wr_addr = 3'd2; dat_in = 8'h77; ngtvIn = 1'b1;
    expect_val("flags_hold_on_write", 16'h0005);
    expect_val("r2_written", 16'h0077);
    tick(); idle_inputs(); rd_addrA = 3'd2; #1;
    obs.push_back(16'({zeroOut, ngtvOut, scryOut}));
    obs.push_back(16'(datA_out));
    wr_en = 1'b1; wr_addr = 3'd6; dat_in = 8'h99; flg_en = 1'b1; ngtvIn = 1'b1;
    expect_val("flags_both_en", 16'h0002);
    expect_val("r6_both_en", 16'h0099);
    tick(); idle_inputs(); rd_addrB = 3'd6; #1;
    obs.push_back(16'({zeroOut, ngtvOut, scryOut}));
    obs.push_back(16'(datB_out));
    while (sb_val.size() != 0) begin
      nm = sb_name.pop_front(); ev = sb_val.pop_front();
      if (obs.size() != 0) ov = obs.pop_front(); else ov = 'x;
      checks++;
      if (ov !== ev) begin errors++; $display("[TB] FAIL %s: got %h expected %h", nm, ov, ev); end
    end
    obs.delete();
  endtask

  task automatic test_bypass();
    string nm; logic [15:0] ev, ov;
    wr_en = 1'b1; wr_addr = 3'd5; dat_in = 8'h3C; rd_addrA = 3'd5; rd_addrB = 3'd4;
    expect_val("bp_same_cycle_A", 16'h003C);
    expect_val("bp_nomatch_B", 16'h0000);
    expect_val("nobp_old_value", 16'h0000);
    #1;
    obs.push_back(16'(datA_bp));
    obs.push_back(16'(datB_bp));
    obs.push_back(16'(datA_out));
    tick(); idle_inputs();
    rd_addrA = 3'd5; wr_addr = 3'd5; dat_in = 8'hAA;
    expect_val("nobp_next_cycle", 16'h003C);
    expect_val("bp_no_wr_en", 16'h003C);
    #1;
    obs.push_back(16'(datA_out));
    obs.push_back(16'(datA_bp));
    while (sb_val.size() != 0) begin
      nm = sb_name.pop_front(); ev = sb_val.pop_front();
      if (obs.size() != 0) ov = obs.pop_front(); else ov = 'x;
      checks++;
      if (ov !== ev) begin errors++; $display("[TB] FAIL %s: got %h expected %h", nm, ov, ev); end
    end
    obs.delete();
    idle_inputs();
  endtask

  task automatic test_bank_switch();
    string nm; logic [15:0] ev, ov;
    wr_en = 1'b1; wr_addr = 3'd1; dat_in = 8'h11; bank_sw = 1'b1; bank_sel = 1'b1;
    expect_val("bank_after_sw", 16'h0001);
    expect_val("bank1_r1", 16'h0000);
    expect_val("bank1_flags", 16'h0000);
    tick(); idle_inputs(); rd_addrA = 3'd1; #1;
    obs.push_back(16'(bank_cur));
    obs.push_back(16'(datA_out));
    obs.push_back(16'({zeroOut, ngtvOut, scryOut}));
    wr_en = 1'b1; wr_addr = 3'd1; dat_in = 8'h22; tick(); idle_inputs();
    bank_sw = 1'b1; bank_sel = 1'b0;
    expect_val("bank_back", 16'h0000);
    expect_val("bank0_r1", 16'h0011);
    expect_val("bank0_flags", 16'h0002);
    tick(); idle_inputs(); rd_addrA = 3'd1; #1;
    obs.push_back(16'(bank_cur));
    obs.push_back(16'(datA_out));
    obs.push_back(16'({zeroOut, ngtvOut, scryOut}));
    while (sb_val.size() != 0) begin
      nm = sb_name.pop_front(); ev = sb_val.pop_front();
      if (obs.size() != 0) ov = obs.pop_front(); else ov = 'x;
      checks++;
      if (ov !== ev) begin errors++; $display("[TB] FAIL %s: got %h expected %h", nm, ov, ev); end
    end
    obs.delete();
  endtask

  task automatic test_copy();
    string nm; logic [15:0] ev, ov;
    int d0, nbusy, done_at;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); dat_in = 8'h10 + 8'(i); tick();
    end
    idle_inputs(); flg_en = 1'b1; zeroIn = 1'b1; tick(); idle_inputs();
    d0 = done_cnt; nbusy = 0; done_at = -1;
    cpy_req = 1'b1; cpy_bank = 1'b1;
    expect_val("busy_on_req_cycle", 16'h0000); #1;
    obs.push_back(16'(busy));
    tick();
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      if (c == 2) begin cpy_req = 1'b1; cpy_bank = 1'b1; end
      if (c == 3) begin bank_sw = 1'b1; bank_sel = 1'b1; end
      if (c == 4) begin wr_en = 1'b1; wr_addr = 3'd4; dat_in = 8'hEE; end
      if (c == 7) begin flg_en = 1'b1; zeroIn = 1'b1; ngtvIn = 1'b1; end
      #1;
      if (!busy) break;
      nbusy++;
      if (cpy_done) done_at = c;
      tick();
    end
    idle_inputs();
    expect_val("copy_busy_cycles", 16'd8);
    expect_val("copy_done_cycle", 16'd7);
    expect_val("copy_done_pulses", 16'd1);
    expect_val("bank_sw_during_copy", 16'h0000);
    expect_val("src_r4_forwarded", 16'h00EE);
    expect_val("src_flags_last", 16'h0006);
    rd_addrA = 3'd4; #1;
    obs.push_back(16'(nbusy));
    obs.push_back(16'(done_at));
    obs.push_back(16'(done_cnt - d0));
    obs.push_back(16'(bank_cur));
    obs.push_back(16'(datA_out));
    obs.push_back(16'({zeroOut, ngtvOut, scryOut}));
    bank_sw = 1'b1; bank_sel = 1'b1; tick(); idle_inputs();
    for (int i = 0; i < 8; i++) begin
      expect_val($sformatf("dst_r%0d", i), (i == 4) ? 16'h00EE : 16'h0010 + 16'(i));
      rd_addrB = 3'(i); #1;
      obs.push_back(16'(datB_out));
    end
    expect_val("dst_flags", 16'h0006);
    obs.push_back(16'({zeroOut, ngtvOut, scryOut}));
    while (sb_val.size() != 0) begin
      nm = sb_name.pop_front(); ev = sb_val.pop_front();
      if (obs.size() != 0) ov = obs.pop_front(); else ov = 'x;
      checks++;
      if (ov !== ev) begin errors++; $display("[TB] FAIL %s: got %h expected %h", nm, ov, ev); end
    end
    obs.delete();
  endtask

  task automatic test_edge_cases();
    string nm; logic [15:0] ev, ov;
    int d0;
    idle_inputs(); d0 = done_cnt;
    cpy_req = 1'b1; cpy_bank = 1'b1;
    expect_val("self_copy_no_busy", 16'h0000);
    tick(); idle_inputs(); #1;
    obs.push_back(16'(busy));
    cpy_req = 1'b1; cpy_bank = 1'b0; bank_sw = 1'b1; bank_sel = 1'b0;
    expect_val("copy_with_sw_no_busy", 16'h0000);
    expect_val("copy_with_sw_bank", 16'h0000);
    tick(); idle_inputs(); #1;
    obs.push_back(16'(busy));
    obs.push_back(16'(bank_cur));
    tick();
    expect_val("dropped_no_done", 16'h0000);
    obs.push_back(16'(done_cnt - d0));
    cpy_req = 1'b1; cpy_bank = 1'b1; tick(); idle_inputs();
    tick(); tick();
    reset = 1'b1;
    expect_val("busy_copy_cycle3", 16'h0001); #1;
    obs.push_back(16'(busy));
    tick(); idle_inputs();
    expect_val("busy_after_abort", 16'h0000); #1;
    obs.push_back(16'(busy));
    for (int i = 0; i < 10; i++) tick();
    expect_val("abort_no_done", 16'h0000);
    obs.push_back(16'(done_cnt - d0));
    bank_sw = 1'b1; bank_sel = 1'b1; tick(); idle_inputs();
    expect_val("bank1_after_abort", 16'h0001);
    obs.push_back(16'(bank_cur));
    for (int i = 0; i < 8; i++) begin
      expect_val($sformatf("bank1_cleared_r%0d", i), 16'h0000);
      rd_addrA = 3'(i); #1;
      obs.push_back(16'(datA_out));
    end
    expect_val("bank1_flags_cleared", 16'h0000);
    obs.push_back(16'({zeroOut, ngtvOut, scryOut}));
    while (sb_val.size() != 0) begin
      nm = sb_name.pop_front(); ev = sb_val.pop_front();
      if (obs.size() != 0) ov = obs.pop_front(); else ov = 'x;
      checks++;
      if (ov !== ev) begin errors++; $display("[TB] FAIL %s: got %h expected %h", nm, ov, ev); end
    end
    obs.delete();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_flag_decouple();
    test_bypass();
    test_bank_switch();
    test_copy();
    test_edge_cases();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
